cu_sequencer: RTL and testbench

- Sequential state generator for the Complex CPU control unit.
- Drives the one-hot `CPU_state` vector that the combinational control-signal decoder turns into register loads, ALU select and system-bus select.
- Steps through fetch1→fetch2→fetch3, dispatches on the opcode to the start state of the matching execute routine, walks that routine, then returns to fetch1.
- Resolves conditional branches from the NZCV flags and counts retired instructions.

---
 rtl/cu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_cu_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cu_sequencer.sv
// rtl/cu_sequencer.sv - Complex CPU control-unit state sequencer (optional trap: CU_SEQ_ILLEGAL_TRAP_EN)
// Fetch/dispatch/execute walker with branch resolution and retired-instruction counter.
module cu_sequencer #(
  parameter int STATES = 40,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [4:0]        opcode,
  input  logic [3:0]        nzcv,
  output logic [STATES-1:0] CPU_state,
  output logic [5:0]        state_idx,
  output logic              branch_taken,
  output logic              instr_done,
  output logic              illegal_op,
  output logic              trapped,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [5:0] {
    S_FETCH1 = 6'd0, S_FETCH2, S_FETCH3,
    S_NOP1, S_MOV1, S_ALTMOV1, S_ALTMOV2, S_LDR1, S_LDR2,
    S_ALTLDR1, S_ALTLDR2, S_ALTLDR3, S_ALTLDR4,
    S_STR1, S_STR2, S_STR3, S_STR4,
    S_ALTSTR1, S_ALTSTR2, S_ALTSTR3, S_ALTSTR4,
    S_CMP1, S_B1, S_BGT1, S_BLT1, S_BEQ1,
    S_ADD1, S_ADD2, S_SUB1, S_SUB2, S_MUL1, S_MUL2,
    S_LSR1, S_LSR2, S_AND1, S_AND2, S_OR1, S_OR2, S_MVN1, S_MVN2
  } state_t;

  state_t             state, state_d;
  state_t             disp;
  logic               legal;
  logic               br_cond;
  logic               last;
  logic               branch_q, branch_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               trapped_q;
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
  logic               trapped_d;
`endif

  logic n_f, z_f, v_f;
  assign n_f = nzcv[3];
  assign z_f = nzcv[2];
  assign v_f = nzcv[0];

  // Opcode decode to routine start state; illegal codes fall back to nop1.
  always_comb begin
    disp  = S_NOP1;
    legal = 1'b1;
    case (opcode)
      5'd0:    disp = S_NOP1;
      5'd1:    disp = S_MOV1;
      5'd2:    disp = S_ALTMOV1;
      5'd3:    disp = S_LDR1;
      5'd4:    disp = S_ALTLDR1;
      5'd5:    disp = S_STR1;
      5'd6:    disp = S_ALTSTR1;
      5'd7:    disp = S_CMP1;
      5'd8:    disp = S_B1;
      5'd9:    disp = S_BGT1;
      5'd10:   disp = S_BLT1;
      5'd11:   disp = S_BEQ1;
      5'd12:   disp = S_ADD1;
      5'd13:   disp = S_SUB1;
      5'd14:   disp = S_MUL1;
      5'd15:   disp = S_LSR1;
      5'd16:   disp = S_AND1;
      5'd17:   disp = S_OR1;
      5'd18:   disp = S_MVN1;
      default: begin
        disp  = S_NOP1;
        legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (opcode)
      5'd8:    br_cond = 1'b1;
      5'd9:    br_cond = !z_f && (n_f == v_f);
      5'd10:   br_cond = (n_f != v_f);
      5'd11:   br_cond = z_f;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    last = 1'b0;
    case (state)
      S_NOP1, S_MOV1, S_ALTMOV2, S_LDR2, S_ALTLDR4, S_STR4, S_ALTSTR4,
      S_CMP1, S_B1, S_BGT1, S_BLT1, S_BEQ1,
      S_ADD2, S_SUB2, S_MUL2, S_LSR2, S_AND2, S_OR2, S_MVN2: last = 1'b1;
      default: last = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
    trapped_d = trapped_q;
`endif
    if (!hold) begin
      branch_d  = 1'b0;
      illegal_d = 1'b0;
      if (trapped_q) begin
        state_d = S_FETCH1;
      end else if (state == S_FETCH3) begin
        branch_d = br_cond;
        if (legal) begin
          state_d = disp;
        end else begin
          illegal_d = 1'b1;
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
          state_d   = S_FETCH1;
          trapped_d = 1'b1;
`else
          state_d   = S_NOP1;
`endif
        end
      end else if (last) begin
        state_d   = S_FETCH1;
        retired_d = retired_q + 1'b1;
      end else begin
        state_d = state_t'(state + 6'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH1;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state     <= state_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

`ifdef CU_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) trapped_q <= 1'b0;
    else     trapped_q <= trapped_d;
  end
`else
  assign trapped_q = 1'b0;
`endif

  always_comb begin
    CPU_state        = '0;
    CPU_state[state] = 1'b1;
  end

  assign state_idx    = state;
  assign branch_taken = branch_q;
  assign instr_done   = last;
  assign illegal_op   = illegal_q;
  assign trapped      = trapped_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// tb/tb_cu_sequencer.sv - directed table-driven bench for cu_sequencer
// Counter width reduced to 4 so the wrap case is reachable quickly.
module tb_cu_sequencer;

  localparam int STATES = 40;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst, hold;
  logic [4:0]        opcode;
  logic [3:0]        nzcv;
  logic [STATES-1:0] CPU_state;
  logic [5:0]        state_idx;
  logic              branch_taken, instr_done, illegal_op, trapped;
  logic [CNT_W-1:0]  retired;

  cu_sequencer #(.STATES(STATES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hold(hold), .opcode(opcode), .nzcv(nzcv),
    .CPU_state(CPU_state), .state_idx(state_idx), .branch_taken(branch_taken),
    .instr_done(instr_done), .illegal_op(illegal_op), .trapped(trapped),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic [3:0] flags;
    int         start;
    int         len;
    logic       br;
    logic       ill;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_ret;
  vec_t       vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input int idx);
    logic [STATES-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    check({name, "_idx"}, 64'(state_idx), 64'(idx));
    check({name, "_onehot"}, 64'(CPU_state), 64'(oh));
  endtask

  task automatic run_instr(input vec_t v);
    opcode = v.op;
    nzcv   = v.flags;
    check_state("fetch1", 0);
    step();
    check_state("fetch2", 1);
    step();
    check_state("fetch3", 2);
    step();
    for (int k = 0; k < v.len; k++) begin
      check_state("exec", v.start + k);
      check("instr_done", 64'(instr_done), 64'(k == v.len - 1));
      check("branch_taken", 64'(branch_taken), 64'(v.br));
      check("illegal_op", 64'(illegal_op), 64'(v.ill));
      check("retired_mid", 64'(retired), 64'(exp_ret));
      step();
    end
    exp_ret = exp_ret + 4'd1;
    check_state("return", 0);
    check("retired_post", 64'(retired), 64'(exp_ret));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back('{5'd0,  4'b0000, 3,  1, 1'b0, 1'b0});
    vecs.push_back('{5'd1,  4'b0000, 4,  1, 1'b0, 1'b0});
    vecs.push_back('{5'd2,  4'b0000, 5,  2, 1'b0, 1'b0});
    vecs.push_back('{5'd3,  4'b0000, 7,  2, 1'b0, 1'b0});
    vecs.push_back('{5'd4,  4'b0000, 9,  4, 1'b0, 1'b0});
    vecs.push_back('{5'd5,  4'b0000, 13, 4, 1'b0, 1'b0});
    vecs.push_back('{5'd6,  4'b0000, 17, 4, 1'b0, 1'b0});
    vecs.push_back('{5'd7,  4'b1111, 21, 1, 1'b0, 1'b0});
    vecs.push_back('{5'd8,  4'b0000, 22, 1, 1'b1, 1'b0});
    vecs.push_back('{5'd9,  4'b0000, 23, 1, 1'b1, 1'b0});
    vecs.push_back('{5'd9,  4'b0100, 23, 1, 1'b0, 1'b0});
    vecs.push_back('{5'd9,  4'b1001, 23, 1, 1'b1, 1'b0});
    vecs.push_back('{5'd9,  4'b1000, 23, 1, 1'b0, 1'b0});
    vecs.push_back('{5'd10, 4'b1000, 24, 1, 1'b1, 1'b0});
    vecs.push_back('{5'd10, 4'b1001, 24, 1, 1'b0, 1'b0});
    vecs.push_back('{5'd11, 4'b0000, 25, 1, 1'b0, 1'b0});
    vecs.push_back('{5'd11, 4'b0100, 25, 1, 1'b1, 1'b0});
    vecs.push_back('{5'd12, 4'b0000, 26, 2, 1'b0, 1'b0});
    vecs.push_back('{5'd13, 4'b0000, 28, 2, 1'b0, 1'b0});
    vecs.push_back('{5'd14, 4'b0000, 30, 2, 1'b0, 1'b0});
    vecs.push_back('{5'd15, 4'b0000, 32, 2, 1'b0, 1'b0});
    vecs.push_back('{5'd16, 4'b0000, 34, 2, 1'b0, 1'b0});
    vecs.push_back('{5'd17, 4'b0000, 36, 2, 1'b0, 1'b0});
    vecs.push_back('{5'd18, 4'b0000, 38, 2, 1'b0, 1'b0});
`ifndef CU_SEQ_ILLEGAL_TRAP_EN
    vecs.push_back('{5'd25, 4'b0000, 3,  1, 1'b0, 1'b1});
`endif

    rst = 1'b1; hold = 1'b0; opcode = 5'd0; nzcv = 4'd0;
    step();
    step();
    check_state("reset", 0);
    check("reset_retired", 64'(retired), 64'd0);
    check("reset_branch", 64'(branch_taken), 64'd0);
    check("reset_illegal", 64'(illegal_op), 64'd0);
    check("reset_trapped", 64'(trapped), 64'd0);
    check("reset_done", 64'(instr_done), 64'd0);
    rst = 1'b0;
    exp_ret = 4'd0;

    foreach (vecs[i]) run_instr(vecs[i]);

    // Hold inside ALTldr2, then inside its last state.
    opcode = 5'd4;
    step(); step(); step(); step();
    check_state("hold_entry", 10);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_state("hold_frozen", 10);
      check("hold_retired", 64'(retired), 64'(exp_ret));
    end
    hold = 1'b0;
    step();
    check_state("hold_rel1", 11);
    step();
    check_state("hold_rel2", 12);
    hold = 1'b1;
    step();
    check_state("hold_last", 12);
    check("hold_last_done", 64'(instr_done), 64'd1);
    check("hold_last_retired", 64'(retired), 64'(exp_ret));
    hold = 1'b0;
    step();
    exp_ret = exp_ret + 4'd1;
    check_state("hold_done", 0);
    check("hold_done_retired", 64'(retired), 64'(exp_ret));

    // Counter wrap 15 -> 0.
    for (int i = 0; i < 16 && exp_ret != 4'd15; i++) run_instr(vecs[0]);
    check("wrap_pre", 64'(retired), 64'd15);
    run_instr(vecs[0]);
    check("wrap_zero", 64'(retired), 64'd0);

`ifdef CU_SEQ_ILLEGAL_TRAP_EN
    opcode = 5'd25;
    step(); step(); step();
    check_state("trap_entry", 0);
    check("trap_flag", 64'(trapped), 64'd1);
    check("trap_illegal", 64'(illegal_op), 64'd1);
    step();
    check("trap_illegal_pulse", 64'(illegal_op), 64'd0);
    opcode = 5'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_state("trap_hold", 0);
      check("trap_stays", 64'(trapped), 64'd1);
    end
    check("trap_retired", 64'(retired), 64'(exp_ret));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("trap_cleared", 64'(trapped), 64'd0);
    exp_ret = 4'd0;
`endif

    // Reset asserted mid-ALTstr (state 18).
    opcode = 5'd6;
    step(); step(); step(); step();
    check_state("altstr_mid", 18);
    rst = 1'b1;
    step();
    check_state("midreset1", 0);
    step();
    rst = 1'b0;
    check_state("midreset2", 0);
    check("midreset_retired", 64'(retired), 64'd0);
    check("midreset_branch", 64'(branch_taken), 64'd0);
    check("midreset_illegal", 64'(illegal_op), 64'd0);
    check("midreset_trapped", 64'(trapped), 64'd0);
    check("midreset_done", 64'(instr_done), 64'd0);
    exp_ret = 4'd0;
    run_instr(vecs[17]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
